// File: rtl/raabb_fp_pkg.sv
// Shared definitions for the ray-AABB floating-point blocks (FloPoCo 11/21 words).
package raabb_fp_pkg;
    localparam int W  = 35;
    localparam int WE = 11;
    localparam int WF = 21;

    localparam logic [1:0] EXC_ZERO   = 2'b00;
    localparam logic [1:0] EXC_NORMAL = 2'b01;
    localparam logic [1:0] EXC_INF    = 2'b10;
    localparam logic [1:0] EXC_NAN    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S1,
        ST_S2,
        ST_S3,
        ST_DONE
    } state_t;

    // Destination of a comparator result, carried alongside the comparator pipeline.
    typedef enum logic [2:0] {
        TAG_NONE,
        TAG_TMIN1,
        TAG_TMAX1,
        TAG_TMIN,
        TAG_TMAX,
        TAG_HIT
    } tag_t;
endpackage

// File: rtl/fp_cmp_gt.sv
// Pipelined a > b: sign/exception of a-b through CMP_LAT-1 stages, then a decode register.
module fp_cmp_gt #(
    parameter int W       = 35,
    parameter int CMP_LAT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt
);
    import raabb_fp_pkg::*;

    logic           rst;
    logic [1:0]     ea, eb, r_exc;
    logic           sa, sb, r_sgn, a_gt, a_lt;
    logic [W-4:0]   ma, mb;
    logic [CMP_LAT-2:0][2:0] sub_q;
    logic           gt_q;

    assign rst = ~rst_n;

    // Sign/exception of a-b as the subtractor reports them; finite results come out normal.
    always_comb begin
        ea = a[W-1:W-2];
        eb = b[W-1:W-2];
        sa = a[W-3];
        sb = b[W-3];
        ma = a[W-4:0];
        mb = b[W-4:0];
        a_gt = 1'b0;
        a_lt = 1'b0;
        if (ea == EXC_ZERO && eb != EXC_ZERO) begin
            a_gt = sb;
            a_lt = ~sb;
        end else if (eb == EXC_ZERO && ea != EXC_ZERO) begin
            a_gt = ~sa;
            a_lt = sa;
        end else if (ea != EXC_ZERO) begin
            if (sa != sb) begin
                a_gt = ~sa;
                a_lt = sa;
            end else if (ma != mb) begin
                a_gt = (ma > mb) ^ sa;
                a_lt = ~a_gt;
            end
        end
        r_exc = EXC_NORMAL;
        r_sgn = a_lt;
        if (ea == EXC_NAN || eb == EXC_NAN || (ea == EXC_INF && eb == EXC_INF && sa == sb)) begin
            r_exc = EXC_NAN;
            r_sgn = 1'b0;
        end else if (ea == EXC_INF) begin
            r_exc = EXC_INF;
            r_sgn = sa;
        end else if (eb == EXC_INF) begin
            r_exc = EXC_INF;
            r_sgn = ~sb;
        end else if (!a_gt && !a_lt) begin
            r_exc = EXC_ZERO;
            r_sgn = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q <= '0;
            gt_q  <= 1'b0;
        end else begin
            sub_q[0] <= {r_exc, r_sgn};
            for (int i = 1; i < CMP_LAT - 1; i++) sub_q[i] <= sub_q[i-1];
            gt_q <= (sub_q[CMP_LAT-2][2:1] == EXC_NORMAL) && !sub_q[CMP_LAT-2][0];
        end
    end

    assign gt = gt_q;
endmodule

// File: rtl/ray_slab_cmp_sched.sv
// Resolves tmin=max(near), tmax=min(far) and the slab hit using one shared pipelined comparator.
module ray_slab_cmp_sched #(
    parameter int W       = 35,
    parameter int CMP_LAT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] near_x,
    input  logic [W-1:0] near_y,
    input  logic [W-1:0] near_z,
    input  logic [W-1:0] far_x,
    input  logic [W-1:0] far_y,
    input  logic [W-1:0] far_z,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_hit,
    output logic         out_nan,
    output logic [W-1:0] out_tmin,
    output logic [W-1:0] out_tmax
);
    import raabb_fp_pkg::*;

    localparam int CW = $clog2(CMP_LAT + 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    in_ready_q, accept, cmp_gt;
    logic [W-1:0]            nx_q, ny_q, nz_q, fx_q, fy_q, fz_q;
    logic [W-1:0]            tmin1_q, tmax1_q, tmin_q, tmax_q;
    logic [W-1:0]            cmp_a, cmp_b, cmp_a_q, cmp_b_q;
    logic                    nan_q, hit_q;
    logic [2:0]              issue_tag, tag_out;
    logic [CMP_LAT-1:0][2:0] tag_q;

    assign accept  = in_valid && in_ready_q;
    assign tag_out = tag_q[CMP_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= (state_d == ST_IDLE);
        end
    end

    // S1/S2 issue at cnt 0 and 1 and move on at cnt==CMP_LAT; S3 ends when its tagged result lands.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = ST_S1;
                cnt_d   = '0;
            end
            ST_S1: if (cnt_q == CW'(CMP_LAT)) begin
                state_d = ST_S2;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            ST_S2: if (cnt_q == CW'(CMP_LAT)) begin
                state_d = ST_S3;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            ST_S3: if (tag_out == TAG_HIT) state_d = ST_DONE;
                   else if (cnt_q != CW'(CMP_LAT)) cnt_d = cnt_q + 1'b1;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmp_a     = cmp_a_q;
        cmp_b     = cmp_b_q;
        issue_tag = TAG_NONE;
        out_valid = (state_q == ST_DONE);
        case (state_q)
            ST_S1: if (cnt_q == CW'(0)) begin
                cmp_a = ny_q; cmp_b = nx_q; issue_tag = TAG_TMIN1;
            end else if (cnt_q == CW'(1)) begin
                cmp_a = fx_q; cmp_b = fy_q; issue_tag = TAG_TMAX1;
            end
            ST_S2: if (cnt_q == CW'(0)) begin
                cmp_a = nz_q; cmp_b = tmin1_q; issue_tag = TAG_TMIN;
            end else if (cnt_q == CW'(1)) begin
                cmp_a = tmax1_q; cmp_b = fz_q; issue_tag = TAG_TMAX;
            end
            ST_S3: if (cnt_q == CW'(1)) begin
                cmp_a = tmin_q; cmp_b = tmax_q; issue_tag = TAG_HIT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {nx_q, ny_q, nz_q, fx_q, fy_q, fz_q} <= '0;
            {tmin1_q, tmax1_q, tmin_q, tmax_q}   <= '0;
            cmp_a_q <= '0;
            cmp_b_q <= '0;
            tag_q   <= '0;
            nan_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            cmp_a_q <= cmp_a;
            cmp_b_q <= cmp_b;
            tag_q   <= {tag_q[CMP_LAT-2:0], issue_tag};
            if (accept) begin
                nx_q <= near_x; ny_q <= near_y; nz_q <= near_z;
                fx_q <= far_x;  fy_q <= far_y;  fz_q <= far_z;
                nan_q <= (near_x[W-1:W-2] == EXC_NAN) || (near_y[W-1:W-2] == EXC_NAN) ||
                         (near_z[W-1:W-2] == EXC_NAN) || (far_x[W-1:W-2] == EXC_NAN) ||
                         (far_y[W-1:W-2] == EXC_NAN) || (far_z[W-1:W-2] == EXC_NAN);
            end
            case (tag_out)
                TAG_TMIN1: tmin1_q <= cmp_gt ? ny_q : nx_q;
                TAG_TMAX1: tmax1_q <= cmp_gt ? fy_q : fx_q;
                TAG_TMIN:  tmin_q  <= cmp_gt ? nz_q : tmin1_q;
                TAG_TMAX:  tmax_q  <= cmp_gt ? fz_q : tmax1_q;
                TAG_HIT:   hit_q   <= !cmp_gt && !nan_q &&
                                      (tmax_q[W-1:W-2] == EXC_ZERO || !tmax_q[W-3]);
                default: ;
            endcase
        end
    end

    fp_cmp_gt #(.W(W), .CMP_LAT(CMP_LAT)) u_cmp (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (cmp_a),
        .b     (cmp_b),
        .gt    (cmp_gt)
    );

    assign in_ready = in_ready_q;
    assign out_hit  = hit_q;
    assign out_nan  = nan_q;
    assign out_tmin = tmin_q;
    assign out_tmax = tmax_q;
endmodule

// File: tb/tb_ray_slab_cmp_sched.sv
// Scoreboarded bench for ray_slab_cmp_sched: real-valued reference model, latency and handshake checks.
module tb_ray_slab_cmp_sched;
    localparam int W   = 35;
    localparam int L   = 3;
    localparam int LAT = 5 + 3 * L;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_hit, out_nan;
    logic [W-1:0] near_x = '0, near_y = '0, near_z = '0, far_x = '0, far_y = '0, far_z = '0;
    logic [W-1:0] out_tmin, out_tmax;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] tmin;
        logic [W-1:0] tmax;
        logic         hit;
        logic         nan;
    } exp_t;
    exp_t sb_q[$];

    int vec_cnt = 0;
    int miss_cnt = 0;

    ray_slab_cmp_sched #(.W(W), .CMP_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .near_x(near_x), .near_y(near_y), .near_z(near_z),
        .far_x(far_x), .far_y(far_y), .far_z(far_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit), .out_nan(out_nan),
        .out_tmin(out_tmin), .out_tmax(out_tmax)
    );

    function automatic logic [W-1:0] fpw(input bit s, input int e, input int f);
        return {2'b01, s, e[10:0], f[20:0]};
    endfunction

    function automatic real fp2r(input logic [W-1:0] x);
        real m;
        int  e;
        if (x[34:33] != 2'b01) return 0.0;
        e = int'(x[31:21]) - 1023;
        m = (1.0 + real'(x[20:0]) / 2097152.0) * (2.0 ** e);
        return x[32] ? -m : m;
    endfunction

    function automatic logic [W-1:0] rnd_fp();
        if ($urandom_range(0, 7) == 0) return '0;
        return {2'b01, 1'($urandom_range(0, 1)), 11'(1020 + $urandom_range(0, 6)), 21'($urandom)};
    endfunction

    function automatic exp_t model(input logic [2:0][W-1:0] n, input logic [2:0][W-1:0] f);
        exp_t e;
        e.tmin = n[0];
        e.tmax = f[0];
        e.nan  = 1'b0;
        for (int i = 1; i < 3; i++) begin
            if (fp2r(n[i]) > fp2r(e.tmin)) e.tmin = n[i];
            if (fp2r(f[i]) < fp2r(e.tmax)) e.tmax = f[i];
        end
        for (int i = 0; i < 3; i++)
            if (n[i][34:33] == 2'b11 || f[i][34:33] == 2'b11) e.nan = 1'b1;
        e.hit = !e.nan && (fp2r(e.tmin) <= fp2r(e.tmax)) && (fp2r(e.tmax) >= 0.0);
        return e;
    endfunction

    // Offers one ray, waits for acceptance; returns the accept cycle.
    task automatic drive_accept(input logic [2:0][W-1:0] n, input logic [2:0][W-1:0] f,
                                output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < 40 && !in_ready; i++) begin
            @(posedge clk); #1;
        end
        if (!in_ready) begin
            vec_cnt++; miss_cnt++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
            return;
        end
        in_valid = 1'b1;
        {near_z, near_y, near_x} = n;
        {far_z, far_y, far_x}    = f;
        t = cyc;
        sb_q.push_back(model(n, f));
        @(posedge clk); #1;
        in_valid = 1'b0;
        near_x = W'($urandom); near_y = W'($urandom); near_z = W'($urandom);
        far_x  = W'($urandom); far_y  = W'($urandom); far_z  = W'($urandom);
        vec_cnt++;
        if (in_ready !== 1'b0) begin
            miss_cnt++;
            $display("FAIL busy_ready: in_ready=%0b required 0", in_ready);
        end
        ok = 1'b1;
    endtask

    task automatic collect(input int t, input int stall);
        exp_t e;
        logic [W-1:0] s_tmin, s_tmax;
        logic s_hit, s_nan;
        out_ready = (stall == 0);
        for (int i = 0; i < 40 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        e = sb_q.pop_front();
        vec_cnt++;
        if (out_valid !== 1'b1) begin
            miss_cnt++;
            $display("FAIL out_valid_timeout: out_valid=%0b required 1", out_valid);
            out_ready = 1'b0;
            return;
        end
        vec_cnt++;
        if (cyc - t !== LAT) begin
            miss_cnt++;
            $display("FAIL latency: got %0d cycles required %0d", cyc - t, LAT);
        end
        vec_cnt++;
        if (out_hit !== e.hit || out_nan !== e.nan) begin
            miss_cnt++;
            $display("FAIL hit_nan: hit=%0b nan=%0b required hit=%0b nan=%0b", out_hit, out_nan, e.hit, e.nan);
        end
        if (!e.nan) begin
            vec_cnt++;
            if (out_tmin !== e.tmin || out_tmax !== e.tmax) begin
                miss_cnt++;
                $display("FAIL interval: tmin=%h tmax=%h required tmin=%h tmax=%h", out_tmin, out_tmax, e.tmin, e.tmax);
            end
        end
        {s_tmin, s_tmax, s_hit, s_nan} = {out_tmin, out_tmax, out_hit, out_nan};
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            vec_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {out_tmin, out_tmax, out_hit, out_nan} !== {s_tmin, s_tmax, s_hit, s_nan}) begin
                miss_cnt++;
                $display("FAIL hold_stable: valid=%0b ready=%0b tmin=%h tmax=%h required valid=1 ready=0 tmin=%h tmax=%h",
                         out_valid, in_ready, out_tmin, out_tmax, s_tmin, s_tmax);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vec_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL handshake: out_valid=%0b in_ready=%0b required 0 and 1", out_valid, in_ready);
        end
    endtask

    task automatic run_one(input logic [2:0][W-1:0] n, input logic [2:0][W-1:0] f, input int stall);
        int t;
        bit ok;
        drive_accept(n, f, t, ok);
        if (ok) collect(t, stall);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({in_ready, out_valid, out_hit, out_nan} !== 4'b0 || out_tmin !== '0 || out_tmax !== '0) begin
            miss_cnt++;
            $display("FAIL reset_values: ready=%0b valid=%0b hit=%0b nan=%0b tmin=%h tmax=%h required all 0",
                     in_ready, out_valid, out_hit, out_nan, out_tmin, out_tmax);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        vec_cnt++;
        if (in_ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL ready_after_reset: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_plan_vectors();
        logic [W-1:0] one, two, half, three, four, five, six, nan_w;
        one   = fpw(0, 1023, 0);
        two   = fpw(0, 1024, 0);
        half  = fpw(0, 1022, 0);
        three = fpw(0, 1024, 1 << 20);
        four  = fpw(0, 1025, 0);
        five  = fpw(0, 1025, 1 << 19);
        six   = fpw(0, 1025, 1 << 20);
        nan_w = {2'b11, 33'd0};
        run_one({half, two, one}, {six, four, five}, 0);
        run_one({one, one, three}, {five, five, two}, 0);
        run_one({two, two, two}, {two, two, two}, 0);
        run_one({six | 35'h1_0000_0000, four | 35'h1_0000_0000, five | 35'h1_0000_0000},
                {three | 35'h1_0000_0000, two | 35'h1_0000_0000, one | 35'h1_0000_0000}, 0);
        run_one({half, two, one}, {six, nan_w, five}, 0);
    endtask

    task automatic test_backpressure();
        run_one({fpw(0, 1022, 0), fpw(0, 1024, 0), fpw(0, 1023, 0)},
                {fpw(0, 1025, 1 << 20), fpw(0, 1025, 0), fpw(0, 1025, 1 << 19)}, 5);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++)
            run_one({rnd_fp(), rnd_fp(), rnd_fp()}, {rnd_fp(), rnd_fp(), rnd_fp()}, k % 3);
    endtask

    task automatic test_mid_reset();
        int t;
        bit ok;
        bit saw;
        drive_accept({fpw(0, 1022, 0), fpw(0, 1024, 0), fpw(0, 1023, 0)},
                     {fpw(0, 1025, 1 << 20), fpw(0, 1025, 0), fpw(0, 1025, 1 << 19)}, t, ok);
        sb_q.delete();
        if (!ok) return;
        for (int i = 0; i < 20 && cyc < t + 6; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({in_ready, out_valid, out_hit, out_nan} !== 4'b0 || out_tmin !== '0 || out_tmax !== '0) begin
            miss_cnt++;
            $display("FAIL mid_reset_values: ready=%0b valid=%0b hit=%0b nan=%0b tmin=%h tmax=%h required all 0",
                     in_ready, out_valid, out_hit, out_nan, out_tmin, out_tmax);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1'b1;
        end
        out_ready = 1'b0;
        vec_cnt++;
        if (saw !== 1'b0 || in_ready !== 1'b1) begin
            miss_cnt++;
            $display("FAIL stale_after_reset: saw_valid=%0b in_ready=%0b required 0 and 1", saw, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        run_one({fpw(0, 1023, 0), fpw(0, 1023, 0), fpw(0, 1023, 0)},
                {fpw(0, 1024, 0), fpw(0, 1024, 0), fpw(0, 1024, 0)}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
